// File: rtl/dragonfang_pkg.sv
// Shared lane types: functional unit id, execution packet and the
// width of the optional scheduler statistics counters.
package dragonfang_pkg;

  localparam int FUNCTIONAL_UNIT_ID_WIDTH = 3;
  localparam int SCHEDULER_STATS_WIDTH    = 32;

  typedef logic [FUNCTIONAL_UNIT_ID_WIDTH-1:0] functional_unit_id_t;

  typedef struct packed {
    functional_unit_id_t functional_unit_id;
    logic [7:0]          opcode;
    logic [15:0]         operand;
    logic [4:0]          dest_tag;
  } execution_packet_t;

endpackage

// File: rtl/functional_unit_issue_scheduler_if.sv
// Handshake bundle between decode/rename, the issue scheduler and the
// dispatcher. master = upstream/downstream environment, slave = scheduler.
interface functional_unit_issue_scheduler_if #(
  parameter int FUNCTIONAL_UNIT_INPUT_BUS_WIDTH = 4,
  parameter int QUEUE_DEPTH                     = 4
);
  import dragonfang_pkg::*;

  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                                       flush;
  execution_packet_t                          packet_in;
  logic                                       packet_in_valid;
  logic                                       packet_in_ready;
  logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0] functional_unit_ready;
  execution_packet_t                          issued_packet;
  logic                                       issued_valid;
  logic                                       illegal_id;
  logic [COUNT_W-1:0]                         queue_count;

  modport master (
    output flush, packet_in, packet_in_valid, functional_unit_ready,
    input  packet_in_ready, issued_packet, issued_valid, illegal_id, queue_count
  );

  modport slave (
    input  flush, packet_in, packet_in_valid, functional_unit_ready,
    output packet_in_ready, issued_packet, issued_valid, illegal_id, queue_count
  );

endinterface

// File: rtl/issue_queue.sv
// Generic FIFO with push/pop, head peek, occupancy and synchronous flush.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module issue_queue #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  T                      push_data,
  input  logic                  pop,
  output T                      head_data,
  output logic                  head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           full;
  logic           push_ok;
  logic           pop_ok;

  assign count      = wr_ptr - rd_ptr;
  assign full       = count[AW];
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign push_ok    = push && !full;
  assign pop_ok     = pop && head_valid;

  // Pointer state: cleared by reset or flush, otherwise advanced by push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage: data only, no reset needed since occupancy gates its use.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/functional_unit_issue_scheduler.sv
// In-order issue scheduler: buffers execution packets and releases the head
// when its functional unit is ready, at most one per cycle, never to the same
// unit on consecutive cycles. Out-of-range ids are dropped with a pulse.
// Optional statistics counters: define FUNCTIONAL_UNIT_SCHEDULER_STATS_EN.
module functional_unit_issue_scheduler
  import dragonfang_pkg::*;
#(
  parameter int FUNCTIONAL_UNIT_INPUT_BUS_WIDTH = 4,
  parameter int QUEUE_DEPTH                     = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  functional_unit_issue_scheduler_if.slave   bus
`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
  ,
  output logic [SCHEDULER_STATS_WIDTH-1:0]   issue_count,
  output logic [SCHEDULER_STATS_WIDTH-1:0]   stall_count
`endif
);

  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [COUNT_W-1:0]                         count;
  execution_packet_t                          head_pkt;
  logic                                       head_valid;
  logic                                       push;
  logic                                       pop;
  logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0] ready_shifted;
  logic                                       id_legal;
  logic                                       unit_ready;
  logic                                       reserved;
  logic                                       issue_go;
  logic                                       drop;

  execution_packet_t   issue_pkt_p1;
  logic                issue_vld_p1;
  logic                illegal_p1;
  functional_unit_id_t last_issued_id;

  // Ready depends only on registered occupancy and flush, never on unit ready.
  assign bus.packet_in_ready = (count < COUNT_W'(QUEUE_DEPTH)) && !bus.flush;
  assign push                = bus.packet_in_valid && bus.packet_in_ready;

  issue_queue #(
    .DEPTH (QUEUE_DEPTH),
    .T     (execution_packet_t)
  ) u_issue_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.flush),
    .push       (push),
    .push_data  (bus.packet_in),
    .pop        (pop),
    .head_data  (head_pkt),
    .head_valid (head_valid),
    .count      (count)
  );

  // Shifting instead of indexing keeps out-of-range ids from selecting a bit.
  assign ready_shifted = bus.functional_unit_ready >> head_pkt.functional_unit_id;
  assign unit_ready    = ready_shifted[0];
  assign id_legal      = 32'(head_pkt.functional_unit_id) < $unsigned(FUNCTIONAL_UNIT_INPUT_BUS_WIDTH);
  // One-cycle reservation covers the unit's ready-deassert latency.
  assign reserved      = issue_vld_p1 && (head_pkt.functional_unit_id == last_issued_id);
  assign issue_go      = head_valid && !bus.flush && id_legal && unit_ready && !reserved;
  assign drop          = head_valid && !bus.flush && !id_legal;
  assign pop           = issue_go || drop;

  // ---- stage p1: issue register feeding the dispatcher ----
  // Issue register, illegal-id pulse and reservation id.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_vld_p1   <= 1'b0;
      issue_pkt_p1   <= '0;
      illegal_p1     <= 1'b0;
      last_issued_id <= '0;
    end else if (bus.flush) begin
      issue_vld_p1   <= 1'b0;
      issue_pkt_p1   <= '0;
      illegal_p1     <= 1'b0;
    end else begin
      issue_vld_p1   <= issue_go;
      issue_pkt_p1   <= issue_go ? head_pkt : '0;
      illegal_p1     <= drop;
      if (issue_go) last_issued_id <= head_pkt.functional_unit_id;
    end
  end

  assign bus.issued_packet = issue_pkt_p1;
  assign bus.issued_valid  = issue_vld_p1;
  assign bus.illegal_id    = illegal_p1;
  assign bus.queue_count   = count;

`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
  logic [SCHEDULER_STATS_WIDTH-1:0] issue_cnt_q;
  logic [SCHEDULER_STATS_WIDTH-1:0] stall_cnt_q;
  logic                             stall;

  function automatic logic [SCHEDULER_STATS_WIDTH-1:0] sat_inc(
    input logic [SCHEDULER_STATS_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + SCHEDULER_STATS_WIDTH'(1);
  endfunction

  assign stall = head_valid && !issue_go && !drop;

  // Saturating statistics; only reset clears them, flush does not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue_go) issue_cnt_q <= sat_inc(issue_cnt_q);
      if (stall)    stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_functional_unit_issue_scheduler.sv
// Directed bench for functional_unit_issue_scheduler (4 units, depth 4).
module tb_functional_unit_issue_scheduler;
  import dragonfang_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  functional_unit_issue_scheduler_if #(
    .FUNCTIONAL_UNIT_INPUT_BUS_WIDTH (4),
    .QUEUE_DEPTH                     (4)
  ) bus ();

`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
  logic [31:0] issue_count;
  logic [31:0] stall_count;
`endif

  functional_unit_issue_scheduler #(
    .FUNCTIONAL_UNIT_INPUT_BUS_WIDTH (4),
    .QUEUE_DEPTH                     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
    ,
    .issue_count (issue_count),
    .stall_count (stall_count)
`endif
  );

  function automatic execution_packet_t mk(input logic [2:0] id, input logic [4:0] tag);
    execution_packet_t p;
    p.functional_unit_id = id;
    p.opcode             = {3'b101, tag};
    p.operand            = {8'h5A, 3'b000, tag};
    p.dest_tag           = tag;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [2:0] id, input logic [4:0] tag);
    bus.packet_in       = mk(id, tag);
    bus.packet_in_valid = 1'b1;
    tick();
    bus.packet_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.packet_in = '0;
    bus.packet_in_valid = 1'b0;
    bus.functional_unit_ready = '0;
    #2;
    n_cmp++; if (bus.packet_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0b exp=1", bus.packet_in_ready); end
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", bus.issued_valid); end
    n_cmp++; if (bus.issued_packet !== '0) begin n_bad++; $display("FAIL rst_packet got=%h exp=0", bus.issued_packet); end
    n_cmp++; if (bus.illegal_id !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got=%0b exp=0", bus.illegal_id); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", bus.queue_count); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    execution_packet_t exp_p;
    exp_p = mk(3'd2, 5'd3);
    bus.functional_unit_ready = 4'b0100;
    push_one(3'd2, 5'd3);
    n_cmp++; if (bus.queue_count !== 3'd1) begin n_bad++; $display("FAIL single_count_after_accept got=%0d exp=1", bus.queue_count); end
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_early got=%0b exp=0", bus.issued_valid); end
    tick();
    n_cmp++; if (bus.issued_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b exp=1", bus.issued_valid); end
    n_cmp++; if (bus.issued_packet !== exp_p) begin n_bad++; $display("FAIL single_packet got=%h exp=%h", bus.issued_packet, exp_p); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL single_count got=%0d exp=0", bus.queue_count); end
    tick();
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop got=%0b exp=0", bus.issued_valid); end
    n_cmp++; if (bus.issued_packet !== '0) begin n_bad++; $display("FAIL single_packet_zero got=%h exp=0", bus.issued_packet); end
    bus.functional_unit_ready = '0;
  endtask

  task automatic test_back_to_back();
    int issues;
    int next_tag;
    logic exp_v;
    bus.functional_unit_ready = 4'b0000;
    for (int i = 0; i < 4; i++) push_one(3'd1, 5'(10 + i));
    bus.packet_in       = mk(3'd1, 5'd14);
    bus.packet_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.packet_in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%0b exp=0", bus.packet_in_ready); end
    n_cmp++; if (bus.queue_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", bus.queue_count); end
    tick();
    bus.packet_in_valid = 1'b0;
    n_cmp++; if (bus.queue_count !== 3'd4) begin n_bad++; $display("FAIL full_count_hold got=%0d exp=4", bus.queue_count); end
    bus.functional_unit_ready = 4'b0010;
    issues = 0;
    next_tag = 10;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_v = ((k % 2) == 0);
      n_cmp++; if (bus.issued_valid !== exp_v) begin n_bad++; $display("FAIL b2b_valid_cycle%0d got=%0b exp=%0b", k, bus.issued_valid, exp_v); end
      if (bus.issued_valid === 1'b1) begin
        n_cmp++; if (bus.issued_packet.dest_tag !== 5'(next_tag)) begin n_bad++; $display("FAIL b2b_order got=%0d exp=%0d", bus.issued_packet.dest_tag, next_tag); end
        issues++;
        next_tag++;
      end
    end
    n_cmp++; if (issues !== 4) begin n_bad++; $display("FAIL b2b_issues got=%0d exp=4", issues); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL b2b_count got=%0d exp=0", bus.queue_count); end
    bus.functional_unit_ready = '0;
    tick();
  endtask

  task automatic test_throughput();
    bus.functional_unit_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.packet_in       = mk(3'(i), 5'(20 + i));
        bus.packet_in_valid = 1'b1;
      end else begin
        bus.packet_in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        n_cmp++; if (bus.issued_valid !== 1'b1) begin n_bad++; $display("FAIL thru_valid%0d got=%0b exp=1", i, bus.issued_valid); end
        n_cmp++; if (bus.issued_packet !== mk(3'(i - 1), 5'(19 + i))) begin n_bad++; $display("FAIL thru_packet%0d got=%h exp=%h", i, bus.issued_packet, mk(3'(i - 1), 5'(19 + i))); end
      end else if (i == 5) begin
        n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL thru_idle got=%0b exp=0", bus.issued_valid); end
      end
    end
    bus.functional_unit_ready = '0;
  endtask

  task automatic test_illegal_id();
    bus.functional_unit_ready = 4'b1111;
    push_one(3'd7, 5'd1);
    push_one(3'd0, 5'd2);
    n_cmp++; if (bus.illegal_id !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse got=%0b exp=1", bus.illegal_id); end
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_no_issue got=%0b exp=0", bus.issued_valid); end
    tick();
    n_cmp++; if (bus.illegal_id !== 1'b0) begin n_bad++; $display("FAIL illegal_once got=%0b exp=0", bus.illegal_id); end
    n_cmp++; if (bus.issued_valid !== 1'b1) begin n_bad++; $display("FAIL illegal_next_valid got=%0b exp=1", bus.issued_valid); end
    n_cmp++; if (bus.issued_packet !== mk(3'd0, 5'd2)) begin n_bad++; $display("FAIL illegal_next_packet got=%h exp=%h", bus.issued_packet, mk(3'd0, 5'd2)); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL illegal_count got=%0d exp=0", bus.queue_count); end
    bus.functional_unit_ready = '0;
    tick();
  endtask

  task automatic test_flush();
    bus.functional_unit_ready = 4'b0000;
    for (int i = 0; i < 3; i++) push_one(3'd1, 5'(4 + i));
    n_cmp++; if (bus.queue_count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count got=%0d exp=3", bus.queue_count); end
    bus.flush                 = 1'b1;
    bus.packet_in             = mk(3'd2, 5'd9);
    bus.packet_in_valid       = 1'b1;
    bus.functional_unit_ready = 4'b1111;
    #1;
    n_cmp++; if (bus.packet_in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%0b exp=0", bus.packet_in_ready); end
    tick();
    bus.flush                 = 1'b0;
    bus.packet_in_valid       = 1'b0;
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", bus.queue_count); end
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%0b exp=0", bus.issued_valid); end
    tick();
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL flush_push_lost got=%0b exp=0", bus.issued_valid); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL flush_count_hold got=%0d exp=0", bus.queue_count); end
    bus.functional_unit_ready = '0;
  endtask

  task automatic test_reset_mid_stream();
    bus.functional_unit_ready = 4'b0000;
    push_one(3'd0, 5'd11);
    push_one(3'd1, 5'd12);
    bus.functional_unit_ready = 4'b0001;
    tick();
    n_cmp++; if (bus.issued_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid got=%0b exp=1", bus.issued_valid); end
    n_cmp++; if (bus.queue_count !== 3'd1) begin n_bad++; $display("FAIL midrst_pre_count got=%0d exp=1", bus.queue_count); end
    bus.functional_unit_ready = 4'b1111;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%0b exp=0", bus.issued_valid); end
    n_cmp++; if (bus.issued_packet !== '0) begin n_bad++; $display("FAIL midrst_packet got=%h exp=0", bus.issued_packet); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL midrst_count got=%0d exp=0", bus.queue_count); end
    n_cmp++; if (bus.packet_in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got=%0b exp=1", bus.packet_in_ready); end
    n_cmp++; if (bus.illegal_id !== 1'b0) begin n_bad++; $display("FAIL midrst_illegal got=%0b exp=0", bus.illegal_id); end
    #1;
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.issued_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_discarded got=%0b exp=0", bus.issued_valid); end
    n_cmp++; if (bus.queue_count !== 3'd0) begin n_bad++; $display("FAIL midrst_count_after got=%0d exp=0", bus.queue_count); end
    bus.functional_unit_ready = '0;
  endtask

`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    bus.functional_unit_ready = 4'b0000;
    push_one(3'd3, 5'd7);
    for (int i = 0; i < 5; i++) tick();
    bus.functional_unit_ready = 4'b1000;
    tick();
    n_cmp++; if (stall_count !== 32'd5) begin n_bad++; $display("FAIL stats_stall got=%0d exp=5", stall_count); end
    n_cmp++; if (issue_count !== 32'd1) begin n_bad++; $display("FAIL stats_issue got=%0d exp=1", issue_count); end
    bus.functional_unit_ready = 4'b0000;
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    push_one(3'd3, 5'd8);
    tick();
    tick();
    tick();
    n_cmp++; if (stall_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL stats_saturate got=%h exp=ffffffff", stall_count); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_throughput();
    test_illegal_id();
    test_flush();
    test_reset_mid_stream();
`ifdef FUNCTIONAL_UNIT_SCHEDULER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
